// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: configures a serially loaded LFSR (taps, then seed) through its
// reg_in line, then free-runs it and packs the serial output into W-bit words.
module lfsr_ctrl #(
  parameter int N     = 8,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N-1:0]     taps,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] num_words,
  input  logic             stop,
  input  logic             lfsr_out,
  output logic             load_tap_reg,
  output logic             load_s_reg,
  output logic             reg_in,
  output logic [W-1:0]     word_out,
  output logic             word_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_TAP,
    LOAD_SEED,
    RUN
  } state_e;

  localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PACK_W = $clog2(W);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);
  localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(W - 1);

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [N-1:0]       shift_q, shift_d;
  logic [N-1:0]       seed_q, seed_d;
  logic [CNT_W-1:0]   numWords_q, numWords_d;
  logic [W-1:0]       pack_q, pack_d;
  logic [PACK_W-1:0]  packCnt_q, packCnt_d;
  logic [CNT_W-1:0]   wordCnt_q, wordCnt_d;
  logic [CNT_W-1:0]   wordCntInc;
  logic [W-1:0]       wordOut_q, wordOut_d;
  logic               wordValid_q, wordValid_d;
  logic               done_q, done_d;

  // Next-state logic: capture on handshake, shift taps then seed out MSB first,
  // then pack lfsr_out into words until the count is reached or stop arrives.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    seed_d      = seed_q;
    numWords_d  = numWords_q;
    pack_d      = pack_q;
    packCnt_d   = packCnt_q;
    wordCnt_d   = wordCnt_q;
    wordOut_d   = wordOut_q;
    wordValid_d = 1'b0;
    done_d      = 1'b0;
    wordCntInc  = wordCnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          state_d    = LOAD_TAP;
          shift_d    = taps;
          seed_d     = seed;
          numWords_d = num_words;
          bitCnt_d   = '0;
          pack_d     = '0;
          packCnt_d  = '0;
          wordCnt_d  = '0;
        end
      end

      LOAD_TAP: begin
        shift_d  = {shift_q[N-2:0], 1'b0};
        bitCnt_d = bitCnt_q + 1'b1;
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          shift_d  = seed_q;
          state_d  = LOAD_SEED;
        end
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      LOAD_SEED: begin
        shift_d  = {shift_q[N-2:0], 1'b0};
        bitCnt_d = bitCnt_q + 1'b1;
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          state_d  = RUN;
        end
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      RUN: begin
        // The cycle carrying the count-end done keeps busy high, then leaves.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          pack_d    = {pack_q[W-2:0], lfsr_out};
          packCnt_d = packCnt_q + 1'b1;
          if (packCnt_q == PACK_LAST) begin
            packCnt_d   = '0;
            wordOut_d   = {pack_q[W-2:0], lfsr_out};
            wordValid_d = 1'b1;
            wordCnt_d   = wordCntInc;
            if ((numWords_q != '0) && (wordCntInc == numWords_q)) begin
              done_d = 1'b1;
            end
          end
          if (stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by the shared reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      seed_q      <= '0;
      numWords_q  <= '0;
      pack_q      <= '0;
      packCnt_q   <= '0;
      wordCnt_q   <= '0;
      wordOut_q   <= '0;
      wordValid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      seed_q      <= seed_d;
      numWords_q  <= numWords_d;
      pack_q      <= pack_d;
      packCnt_q   <= packCnt_d;
      wordCnt_q   <= wordCnt_d;
      wordOut_q   <= wordOut_d;
      wordValid_q <= wordValid_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign load_tap_reg = (state_q == LOAD_TAP);
  assign load_s_reg   = (state_q == LOAD_SEED);
  assign reg_in       = ((state_q == LOAD_TAP) || (state_q == LOAD_SEED)) & shift_q[N-1];
  assign word_out     = wordOut_q;
  assign word_valid   = wordValid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Testbench for lfsr_ctrl: behavioural serially loaded LFSR attached to the
// control outputs, scoreboard queues filled by the stimulus, drained by a monitor.
module tb_lfsr_ctrl;

  localparam int N     = 8;
  localparam int W     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [N-1:0]     taps;
  logic [N-1:0]     seed;
  logic [CNT_W-1:0] num_words;
  logic             stop;
  logic             lfsr_out;
  logic             load_tap_reg;
  logic             load_s_reg;
  logic             reg_in;
  logic [W-1:0]     word_out;
  logic             word_valid;
  logic             busy;
  logic             done;

  typedef struct {
    bit           isWord;
    bit           withDone;
    logic [W-1:0] word;
    int           cyc;
  } expEvent_t;

  typedef struct {
    bit isTap;
    bit bitVal;
  } loadBit_t;

  expEvent_t expEvents[$];
  loadBit_t  expLoad[$];
  expEvent_t ev;
  loadBit_t  lb;

  int checks    = 0;
  int failures  = 0;
  int cycCount  = 0;
  int wordSeen  = 0;
  int doneSeen  = 0;

  logic [N-1:0] modelTap;
  logic [N-1:0] modelState;

  lfsr_ctrl #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .taps        (taps),
    .seed        (seed),
    .num_words   (num_words),
    .stop        (stop),
    .lfsr_out    (lfsr_out),
    .load_tap_reg(load_tap_reg),
    .load_s_reg  (load_s_reg),
    .reg_in      (reg_in),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Cycle index used to time-stamp expected events.
  always @(posedge clk) cycCount <= cycCount + 1;

  // Behavioural LFSR: taps and state shifted in serially, feedback at the LSB.
  assign lfsr_out = modelState[N-1];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      modelTap   <= '0;
      modelState <= '0;
    end else if (load_tap_reg) begin
      modelTap <= {modelTap[N-2:0], reg_in};
    end else if (load_s_reg) begin
      modelState <= {modelState[N-2:0], reg_in};
    end else begin
      modelState <= {modelState[N-2:0], ^(modelState & modelTap)};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the load-bit and event scoreboards whenever the DUT shows them.
  always @(negedge clk) begin
    if (!reset) begin
      if (load_tap_reg || load_s_reg) begin
        if (expLoad.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected load cycle: actual tap=%0b seed=%0b expected none",
                   load_tap_reg, load_s_reg);
        end else begin
          lb = expLoad.pop_front();
          checkOutput("load bit {ready,tap,seed,reg_in}",
                      32'({cfg_ready, load_tap_reg, load_s_reg, reg_in}),
                      32'({1'b0, lb.isTap, !lb.isTap, lb.bitVal}));
        end
      end
      if (word_valid) wordSeen++;
      if (done) doneSeen++;
      if (word_valid || done) begin
        if (expEvents.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected event: actual valid=%0b done=%0b expected none",
                   word_valid, done);
        end else begin
          ev = expEvents.pop_front();
          checkOutput("event {valid,done}", 32'({word_valid, done}),
                      32'({ev.isWord, ev.withDone}));
          if (ev.isWord) checkOutput("word_out", 32'(word_out), 32'(ev.word));
          checkOutput("event cycle", 32'(cycCount), 32'(ev.cyc));
        end
      end
    end
  end

  task automatic pushEvent(input bit isWord, input bit withDone,
                           input logic [W-1:0] word, input int cyc);
    expEvent_t e;
    e.isWord   = isWord;
    e.withDone = withDone;
    e.word     = word;
    e.cyc      = cyc;
    expEvents.push_back(e);
  endtask

  task automatic expectLoad(input logic [N-1:0] t, input logic [N-1:0] s,
                            input int nTap, input int nSeed);
    loadBit_t b;
    for (int i = 0; i < nTap; i++) begin
      b.isTap  = 1'b1;
      b.bitVal = t[N-1-i];
      expLoad.push_back(b);
    end
    for (int i = 0; i < nSeed; i++) begin
      b.isTap  = 1'b0;
      b.bitVal = s[N-1-i];
      expLoad.push_back(b);
    end
  endtask

  // Handshake; returns the cycle index of the first LOAD_TAP cycle.
  task automatic applyStimulus(input logic [N-1:0] t, input logic [N-1:0] s,
                               input logic [CNT_W-1:0] nw, output int c0);
    @(negedge clk);
    for (int i = 0; i < 50 && !cfg_ready; i++) @(negedge clk);
    checkOutput("cfg_ready before handshake", 32'(cfg_ready), 32'd1);
    taps      = t;
    seed      = s;
    num_words = nw;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    c0        = cycCount;
    cfg_valid = 1'b0;
    taps      = ~t;
    seed      = ~s;
    num_words = ~nw;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (expEvents.size() == 0 && expLoad.size() == 0) break;
      @(posedge clk);
    end
    checkOutput({"scoreboard drained: ", name},
                32'(expEvents.size() + expLoad.size()), 32'd0);
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, " {ready,busy,tap,seed,reg_in,valid,done}"},
                32'({cfg_ready, busy, load_tap_reg, load_s_reg, reg_in, word_valid, done}),
                32'(7'b1000000));
    checkOutput({name, " word_out"}, 32'(word_out), 32'd0);
  endtask

  // Counted run of two words: seed word then the next eight LFSR bits.
  task automatic runBasic(input string name);
    int c0, w0, d0;
    w0 = wordSeen;
    d0 = doneSeen;
    expectLoad(8'hB8, 8'h01, N, N);
    applyStimulus(8'hB8, 8'h01, 16'd2, c0);
    pushEvent(1'b1, 1'b0, 8'h01, c0 + 2*N + W);
    pushEvent(1'b1, 1'b1, 8'h1C, c0 + 2*N + 2*W);
    waitDrain(name);
    @(negedge clk);
    checkOutput({name, " idle after done {ready,busy}"}, 32'({cfg_ready, busy}), 32'(2'b10));
    checkOutput({name, " word count"}, 32'(wordSeen - w0), 32'd2);
    checkOutput({name, " done count"}, 32'(doneSeen - d0), 32'd1);
  endtask

  initial begin
    int c0, w0, d0;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    taps      = '0;
    seed      = '0;
    num_words = '0;
    stop      = 1'b0;

    @(negedge clk);
    checkIdleOutputs("reset held");
    reset = 1'b0;
    @(negedge clk);
    checkIdleOutputs("after reset release");

    runBasic("basic");

    // Free run, stop in run cycle 13: one word, done alone, no partial word.
    w0 = wordSeen;
    d0 = doneSeen;
    expectLoad(8'hB8, 8'h01, N, N);
    applyStimulus(8'hB8, 8'h01, 16'd0, c0);
    pushEvent(1'b1, 1'b0, 8'h01, c0 + 2*N + W);
    pushEvent(1'b0, 1'b1, '0, c0 + 2*N + 14);
    repeat (2*N + 13) @(posedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    waitDrain("free-run stop");
    @(negedge clk);
    checkOutput("free-run stop busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("free-run stop word count", 32'(wordSeen - w0), 32'd1);
    checkOutput("free-run stop done count", 32'(doneSeen - d0), 32'd1);

    // Stop during LOAD_TAP cycle 3.
    w0 = wordSeen;
    d0 = doneSeen;
    expectLoad(8'hB8, 8'h01, 4, 0);
    applyStimulus(8'hB8, 8'h01, 16'd2, c0);
    pushEvent(1'b0, 1'b1, '0, c0 + 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    checkOutput("load stop {ready,busy,tap,seed,reg_in}",
                32'({cfg_ready, busy, load_tap_reg, load_s_reg, reg_in}), 32'(5'b10000));
    waitDrain("load stop");
    repeat (10) @(negedge clk);
    checkOutput("load stop word count", 32'(wordSeen - w0), 32'd0);
    checkOutput("load stop done count", 32'(doneSeen - d0), 32'd1);

    // Asynchronous reset in run cycle 10 after the first word was emitted.
    d0 = doneSeen;
    expectLoad(8'hB8, 8'h01, N, N);
    applyStimulus(8'hB8, 8'h01, 16'd0, c0);
    pushEvent(1'b1, 1'b0, 8'h01, c0 + 2*N + W);
    repeat (2*N + 10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkIdleOutputs("async reset mid-run");
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset scoreboard", 32'(expEvents.size() + expLoad.size()), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset no done", 32'(doneSeen - d0), 32'd0);
    runBasic("after reset");

    // cfg_valid with a different seed while busy must be ignored.
    w0 = wordSeen;
    expectLoad(8'hB8, 8'h01, N, N);
    applyStimulus(8'hB8, 8'h01, 16'd2, c0);
    pushEvent(1'b1, 1'b0, 8'h01, c0 + 2*N + W);
    pushEvent(1'b1, 1'b1, 8'h1C, c0 + 2*N + 2*W);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b1;
    taps      = 8'h55;
    seed      = 8'hFF;
    num_words = 16'd1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b1;
    checkOutput("cfg_ready while running", 32'(cfg_ready), 32'd0);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    waitDrain("ignored config");
    @(negedge clk);
    checkOutput("ignored config word count", 32'(wordSeen - w0), 32'd2);
    checkOutput("ignored config idle", 32'({cfg_ready, busy}), 32'(2'b10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lfsr_ctrl.md
# lfsr_ctrl

Sequencer for the serially configured LFSR datapath. It accepts a parallel tap mask and seed through a valid/ready handshake and shifts both into the LFSR over its single `reg_in` line using `load_tap_reg` and `load_s_reg`. It then free-runs the LFSR and packs `lfsr_out` into W-bit words for a fixed word count, or until stopped. It sits between the host/config logic and the `lfsr` instance and owns all of that instance's control inputs.

## Interface
- `N`, 8, LFSR register width; must match the `lfsr` instance's `n`.
- `W`, 8, output word width (≥2).
- `CNT_W`, 16, width of `num_words`.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high; also drives the `lfsr` reset.
- `cfg_valid` input 1: config request.
- `cfg_ready` output 1: high only in IDLE.
- `taps` input N: feedback mask, sampled on handshake.
- `seed` input N: initial state, sampled on handshake.
- `num_words` input CNT_W: words to produce; 0 = unlimited; sampled on handshake.
- `stop` input 1: abort/terminate request.
- `lfsr_out` input 1: serial output of the `lfsr` instance.
- `load_tap_reg` output 1: to `lfsr`.
- `load_s_reg` output 1: to `lfsr`.
- `reg_in` output 1: to `lfsr`.
- `word_out` output W: packed output word.
- `word_valid` output 1: one-cycle strobe.
- `busy` output 1: high in any non-IDLE state.
- `done` output 1: one-cycle strobe at run end.

## Operation
- FSM states:
  - IDLE → LOAD_TAP on `cfg_valid && cfg_ready`.
  - LOAD_TAP → LOAD_SEED after N cycles.
  - LOAD_SEED → RUN after N cycles.
  - RUN → IDLE on word count reached or `stop`.
- Handshake capture: `taps`, `seed` and `num_words` are latched into internal registers. Inputs may change afterwards.
- LOAD_TAP:
  - `load_tap_reg`=1, `load_s_reg`=0.
  - `reg_in` = `taps[N-1-i]` in cycle i (MSB first), i = 0..N-1.
- LOAD_SEED:
  - `load_s_reg`=1, `load_tap_reg`=0.
  - `reg_in` = `seed[N-1-i]` in cycle i.
  - After N cycles the shift register holds `seed`.
- RUN:
  - Both load outputs 0 and `reg_in`=0; the LFSR runs on its own feedback.
  - Each cycle, `lfsr_out` is shifted into the pack register LSB-side: `pack <= {pack[W-2:0], lfsr_out}`.
  - Every W samples: `word_out` ← packed value, `word_valid` pulses, and the word counter increments (CNT_W bits).
- Word count end: when `num_words` ≠ 0 and the counter reaches `num_words`, `done` pulses in the same cycle as that final `word_valid`, and the FSM is IDLE next cycle.
- `num_words`=0: RUN continues until `stop`. The counter wraps silently at 2^CNT_W with no effect.
- `stop`, in any non-IDLE state:
  - Next state is IDLE; the partial word is discarded and no `word_valid` is issued.
  - `done` pulses one cycle.
  - In IDLE, `stop` is ignored.
- `stop` in the same cycle as a final word completes: the word is still emitted, with a single `done` pulse.
- `cfg_valid` while busy: ignored; `cfg_ready`=0 and no capture occurs.
- Outputs are driven from state/counter registers only; there is no combinational path from inputs to outputs except `cfg_ready` (state decode).
- No backpressure: the LFSR advances every clock, so words are strobed and unheld downstream capture is lost. `word_out` holds its value until the next word.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `cfg_ready`=1.
  - `load_tap_reg`=`load_s_reg`=`reg_in`=0.
  - `word_out`=0; `word_valid`=`done`=`busy`=0.
- `reset` asserted mid-operation: immediate return to the reset values with no `done`. The LFSR contents are also cleared by the shared reset.
- Cycle numbering, handshake at rising edge k:
  - Cycles k+1..k+N: LOAD_TAP.
  - Cycles k+N+1..k+2N: LOAD_SEED.
  - Cycles from k+2N+1: RUN.
- `lfsr_out` in run cycle r (r=0 at k+2N+1) is the r-th sequence bit. Bits 0..N-1 equal `seed` MSB first.
- Word j (j≥1): `word_valid` is high in run cycle j·W, i.e. the cycle after its last sample. Bit 0 of the word lands in `word_out[W-1]`.
- `busy` is high from k+1 until the cycle after `done`.
- Back-to-back reconfiguration: a new handshake is possible in the first IDLE cycle after `done`.

## Test plan
- Load sequence: N=W=8, `taps`=8'hB8, `seed`=8'h01, `num_words`=2. Required:
  - `reg_in` = 1,0,1,1,1,0,0,0 under `load_tap_reg`.
  - Then 0,0,0,0,0,0,0,1 under `load_s_reg`.
  - `cfg_ready` low throughout.
- Run data: same configuration with a behavioural LFSR model attached.
  - First `word_out`=8'h01 (the seed) in run cycle 8.
  - Second word matches the model's next 8 bits.
  - `done` coincides with the second `word_valid`, then IDLE with `cfg_ready`=1.
- Free-run and stop: `num_words`=0; assert `stop` in run cycle 13.
  - Exactly 1 `word_valid`; no word for the partial bits.
  - `done` pulses once; `busy` drops.
- Stop during load: `stop` in LOAD_TAP cycle 3.
  - IDLE next cycle; `done` pulses; no `word_valid`.
  - All load outputs are 0 afterwards.
- Reset mid-RUN: assert `reset` asynchronously between clock edges.
  - All outputs go to reset values immediately; no `done`.
  - A new config after release reproduces the first scenario exactly.
- Ignored config: pulse `cfg_valid` with different `seed` while busy.
  - No capture; the output sequence is unchanged.
